vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator with sync, data-enable,
// pixel coordinates, line/frame markers, a frame counter and four test patterns.
module vga_timing_gen #(
    parameter int unsigned COLOR_BITS = 2,
    parameter int unsigned X_BITS     = 10,
    parameter int unsigned Y_BITS     = 10,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          HSYNC_POL  = 1'b0,
    parameter bit          VSYNC_POL  = 1'b0
) (
    input  logic                      vgaClock,
    input  logic                      reset_n,
    input  logic [1:0]                mode,
    input  logic [3*COLOR_BITS-1:0]   fgColor,
    output logic [COLOR_BITS-1:0]     red,
    output logic [COLOR_BITS-1:0]     green,
    output logic [COLOR_BITS-1:0]     blue,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      de,
    output logic [X_BITS-1:0]         x,
    output logic [Y_BITS-1:0]         y,
    output logic                      lineStart,
    output logic                      frameStart,
    output logic [7:0]                frameCount
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [X_BITS-1:0] H_LAST     = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_ACT      = X_BITS'(H_ACTIVE);
    localparam logic [X_BITS-1:0] H_ACT_LAST = X_BITS'(H_ACTIVE - 1);
    localparam logic [X_BITS-1:0] HS_FIRST   = X_BITS'(H_ACTIVE + H_FRONT);
    localparam logic [X_BITS-1:0] HS_LAST    = X_BITS'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [X_BITS-1:0] BAR_W      = X_BITS'(H_ACTIVE / 8);

    localparam logic [Y_BITS-1:0] V_LAST     = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_ACT      = Y_BITS'(V_ACTIVE);
    localparam logic [Y_BITS-1:0] V_ACT_LAST = Y_BITS'(V_ACTIVE - 1);
    localparam logic [Y_BITS-1:0] VS_FIRST   = Y_BITS'(V_ACTIVE + V_FRONT);
    localparam logic [Y_BITS-1:0] VS_LAST    = Y_BITS'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [X_BITS-1:0]       hc_q, hc_d;
    logic [Y_BITS-1:0]       vc_q, vc_d;
    logic [1:0]              mode_q;
    logic [3*COLOR_BITS-1:0] fg_q;
    logic                    started_q;

    logic                    at_origin, active, in_hsync, in_vsync;
    logic [1:0]              mode_eff;
    logic [3*COLOR_BITS-1:0] fg_eff;
    logic [2:0]              bar;
    logic                    checker_on, border_on;
    logic [COLOR_BITS-1:0]   fg_r, fg_g, fg_b;
    logic [COLOR_BITS-1:0]   red_d, green_d, blue_d;

    // Raster counter next state: hc wraps every line, vc advances on hc wrap.
    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
        end
    end

    // Decode of the current raster position and pattern selection.
    always_comb begin
        at_origin = (hc_q == '0) && (vc_q == '0);
        active    = (hc_q < H_ACT) && (vc_q < V_ACT);
        in_hsync  = (hc_q >= HS_FIRST) && (hc_q <= HS_LAST);
        in_vsync  = (vc_q >= VS_FIRST) && (vc_q <= VS_LAST);
        // At the origin the freshly captured inputs drive pixel (0,0) directly.
        mode_eff  = at_origin ? mode    : mode_q;
        fg_eff    = at_origin ? fgColor : fg_q;
        fg_r      = fg_eff[3*COLOR_BITS-1 -: COLOR_BITS];
        fg_g      = fg_eff[2*COLOR_BITS-1 -: COLOR_BITS];
        fg_b      = fg_eff[COLOR_BITS-1:0];
        bar       = 3'(hc_q / BAR_W);
        checker_on = ((((32'(hc_q) ^ 32'(vc_q)) >> 5) & 32'd1) == 32'd0);
        border_on = (hc_q == '0) || (hc_q == H_ACT_LAST) ||
                    (vc_q == '0) || (vc_q == V_ACT_LAST);
        red_d     = '0;
        green_d   = '0;
        blue_d    = '0;
        if (active) begin
            case (mode_eff)
                2'd0: begin
                    red_d = fg_r; green_d = fg_g; blue_d = fg_b;
                end
                2'd1: begin
                    red_d   = {COLOR_BITS{bar[2]}};
                    green_d = {COLOR_BITS{bar[1]}};
                    blue_d  = {COLOR_BITS{bar[0]}};
                end
                2'd2: if (checker_on) begin
                    red_d = fg_r; green_d = fg_g; blue_d = fg_b;
                end
                default: if (border_on) begin
                    red_d = fg_r; green_d = fg_g; blue_d = fg_b;
                end
            endcase
        end
    end

    // Horizontal and vertical raster counters.
    always_ff @(posedge vgaClock or negedge reset_n) begin
        if (!reset_n) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Shadow copies of mode/colour, refreshed only at the start of a frame.
    always_ff @(posedge vgaClock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= '0;
            fg_q   <= '0;
        end else if (at_origin) begin
            mode_q <= mode;
            fg_q   <= fgColor;
        end
    end

    // Registered outputs, all one clock behind the raster counters.
    always_ff @(posedge vgaClock or negedge reset_n) begin
        if (!reset_n) begin
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            hsync      <= ~HSYNC_POL;
            vsync      <= ~VSYNC_POL;
            de         <= 1'b0;
            x          <= '0;
            y          <= '0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            red        <= red_d;
            green      <= green_d;
            blue       <= blue_d;
            hsync      <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync      <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
            de         <= active;
            x          <= active ? hc_q : '0;
            y          <= active ? vc_q : '0;
            lineStart  <= (hc_q == '0) && (vc_q < V_ACT);
            frameStart <= at_origin;
        end
    end

    // Completed-frame counter; the first frame start after reset is not counted.
    always_ff @(posedge vgaClock or negedge reset_n) begin
        if (!reset_n) begin
            frameCount <= '0;
            started_q  <= 1'b0;
        end else if (at_origin) begin
            if (started_q) begin
                frameCount <= frameCount + 8'd1;
            end
            started_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small-geometry instance for frame-level
// behaviour and a default 640x480 instance for line timing and patterns.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance (_s): 16x4 active, line 24 clocks, frame 168 clocks.
    logic       rst_s;
    logic [1:0] mode_s;
    logic [5:0] fg_s;
    logic [1:0] r_s, g_s, b_s;
    logic       hs_s, vs_s, de_s, ls_s, fs_s;
    logic [9:0] x_s, y_s;
    logic [7:0] fc_s;

    // Default instance (_d): 640x480, line 800 clocks.
    logic       rst_d;
    logic [1:0] mode_d;
    logic [5:0] fg_d;
    logic [1:0] r_d, g_d, b_d;
    logic       hs_d, vs_d, de_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;
    logic [7:0] fc_d;

    int k;
    int n_cmp;
    int n_fail;

    vga_timing_gen #(
        .COLOR_BITS(2), .X_BITS(10), .Y_BITS(10),
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_small (
        .vgaClock(clk), .reset_n(rst_s), .mode(mode_s), .fgColor(fg_s),
        .red(r_s), .green(g_s), .blue(b_s), .hsync(hs_s), .vsync(vs_s),
        .de(de_s), .x(x_s), .y(y_s), .lineStart(ls_s), .frameStart(fs_s),
        .frameCount(fc_s)
    );

    vga_timing_gen u_dflt (
        .vgaClock(clk), .reset_n(rst_d), .mode(mode_d), .fgColor(fg_d),
        .red(r_d), .green(g_d), .blue(b_d), .hsync(hs_d), .vsync(vs_d),
        .de(de_d), .x(x_d), .y(y_d), .lineStart(ls_d), .frameStart(fs_d),
        .frameCount(fc_d)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; samples land 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic goto(input int t);
        while (k < t) step();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        k      = 0;
        rst_s  = 1'b0;
        rst_d  = 1'b0;
        mode_s = 2'd0;
        fg_s   = 6'b010101;
        mode_d = 2'd1;
        fg_d   = 6'b000000;
        repeat (3) @(posedge clk);
        #1;

        // Reset values while held in reset.
        check("s_rst_hsync", hs_s, 0);
        check("s_rst_vsync", vs_s, 0);
        check("s_rst_de", de_s, 0);
        check("s_rst_fs", fs_s, 0);
        check("s_rst_fc", fc_s, 0);
        check("d_rst_hsync", hs_d, 1);
        check("d_rst_vsync", vs_d, 1);
        check("d_rst_red", r_d, 0);

        // ---- Small instance: frame-level behaviour ----
        rst_s = 1'b1;
        k = -1;
        step();
        check("s0_fs", fs_s, 1);
        check("s0_ls", ls_s, 1);
        check("s0_de", de_s, 1);
        check("s0_red", r_s, 1);
        check("s0_fc", fc_s, 0);
        check("s0_hsync", hs_s, 0);
        goto(16);  check("s16_de", de_s, 0);  check("s16_red", r_s, 0);
        goto(17);  check("s17_hsync", hs_s, 0);
        goto(18);  check("s18_hsync", hs_s, 1);
        goto(20);  check("s20_hsync", hs_s, 1);
        goto(21);  check("s21_hsync", hs_s, 0);
        goto(50);
        mode_s = 2'd3;
        goto(53);  check("s53_mid_frame_mode", r_s, 1);
        goto(119); check("s119_vsync", vs_s, 0);
        goto(120); check("s120_vsync", vs_s, 1);
        goto(143); check("s143_vsync", vs_s, 1);
        goto(144); check("s144_vsync", vs_s, 0);
        goto(167); check("s167_fs", fs_s, 0);  check("s167_fc", fc_s, 0);
        goto(168); check("s168_fs", fs_s, 1);  check("s168_fc", fc_s, 1);
        check("s168_red", r_s, 1);
        goto(192); check("s_border_0_1", r_s, 1);
        goto(197); check("s_border_5_1", r_s, 0);
        goto(207); check("s_border_15_1", r_s, 1);
        goto(245); check("s_border_5_3", r_s, 1);
        goto(336); check("s336_fs", fs_s, 1);  check("s336_fc", fc_s, 2);
        goto(340); check("s340_x", x_s, 4);
        rst_s = 1'b0;
        #2;
        check("s_async_de", de_s, 0);
        check("s_async_x", x_s, 0);
        check("s_async_fc", fc_s, 0);
        check("s_async_red", r_s, 0);
        @(posedge clk);
        #1;
        check("s_hold_de", de_s, 0);
        rst_s = 1'b1;
        k = -1;
        step();
        check("s_restart_fs", fs_s, 1);
        check("s_restart_ls", ls_s, 1);
        check("s_restart_de", de_s, 1);
        check("s_restart_fc", fc_s, 0);
        check("s_restart_red", r_s, 1);

        // ---- Default instance: colour bars and line timing ----
        rst_d = 1'b1;
        k = -1;
        step();
        check("d0_de", de_d, 1);
        check("d0_x", x_d, 0);
        check("d0_y", y_d, 0);
        check("d0_fs", fs_d, 1);
        check("d0_ls", ls_d, 1);
        check("d0_rgb", {r_d, g_d, b_d}, 0);
        check("d0_hsync", hs_d, 1);
        goto(1);   check("d1_fs", fs_d, 0);  check("d1_x", x_d, 1);
        goto(80);  check("d80_rgb", {r_d, g_d, b_d}, 6'b000011);
        goto(639); check("d639_rgb", {r_d, g_d, b_d}, 6'b111111);
        goto(640); check("d640_de", de_d, 0);  check("d640_rgb", {r_d, g_d, b_d}, 0);
        check("d640_x", x_d, 0);
        goto(655); check("d655_hsync", hs_d, 1);
        goto(656); check("d656_hsync", hs_d, 0);
        goto(751); check("d751_hsync", hs_d, 0);
        goto(752); check("d752_hsync", hs_d, 1);
        goto(800); check("d800_ls", ls_d, 1);  check("d800_y", y_d, 1);
        check("d800_fs", fs_d, 0);  check("d800_vsync", vs_d, 1);

        // ---- Default instance: checker pattern after a mid-frame reset ----
        rst_d = 1'b0;
        #2;
        check("d_async_y", y_d, 0);
        check("d_async_de", de_d, 0);
        mode_d = 2'd2;
        fg_d   = 6'b110000;
        @(posedge clk);
        #1;
        rst_d = 1'b1;
        k = -1;
        step();
        check("c0_red", r_d, 3);
        goto(31);  check("c31_red", r_d, 3);  check("c31_green", g_d, 0);
        goto(32);  check("c32_red", r_d, 0);
        goto(100);
        mode_d = 2'd0;
        fg_d   = 6'b000011;
        goto(200); check("c200_rgb", {r_d, g_d, b_d}, 6'b110000);
        goto(25600); check("c_0_32_red", r_d, 0);
        goto(25632); check("c_32_32_rgb", {r_d, g_d, b_d}, 6'b110000);
        check("c_32_32_y", y_d, 32);
        check("c_32_32_x", x_d, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
